ist_trig_fetch: RTL and testbench
=================================

Name: ist_trig_fetch

Overview:
- Parametrised, synthesisable triangle-fetch stage for the intersection-test (IST) path.
- Pops leaf requests {trig_idx, num_trigs, rid} from the IST request stream and reads num_trigs consecutive triangles from a fixed-latency backing memory.
- Writes each returned triangle into the per-ray triangle SRAM at {slot, cid}, then pushes rid onto the IST response stream.
- Sits between the traversal unit's IST request FIFO and the intersection-test datapath.

Parameters:
- RID_W, 10, ray id width
- TID_W, 6, rid bits below the cid field
- CID_W, 4, cid field width: cid = rid[TID_W +: CID_W]
- NUM_TRIGS_W, 3, triangle-count width; max count 2^NUM_TRIGS_W-1
- CHILD_IDX_W, 16, triangle base index / memory address width
- TRIG_W, 288, triangle record width
- MEM_LAT, 2, backing-memory read latency in cycles (>=1)

Ports:
- clk  in  1  clock
- arst_n  in  1  asynchronous active-low reset
- req_empty_n  in  1  request stream not empty
- req_read  out  1  request pop
- req_dout  in  CHILD_IDX_W+NUM_TRIGS_W+RID_W  {trig_idx, num_trigs, rid}, rid in LSBs
- resp_full_n  in  1  response stream not full
- resp_write  out  1  response push
- resp_din  out  RID_W  completed rid
- mem_rd_en  out  1  backing-memory read strobe
- mem_rd_addr  out  CHILD_IDX_W  read address
- mem_rd_data  in  TRIG_W  read data, valid exactly MEM_LAT cycles after mem_rd_en
- sram_we  out  1  triangle SRAM write enable
- sram_waddr  out  NUM_TRIGS_W+CID_W  {slot, cid}
- sram_wdata  out  TRIG_W  triangle record
- busy  out  1  FSM not IDLE or reads in flight
- err_zero  out  1  sticky: a request with num_trigs==0 was seen

Behaviour:
- Reset: arst_n asynchronous, active-low; clock clk. All outputs are 0, FSM is IDLE, in-flight shift register is cleared, err_zero is 0. If reset is asserted mid-operation, in-flight reads are discarded and no SRAM write or response follows.
- FSM states: IDLE, ISSUE, DRAIN, RESP.
- IDLE:
  - req_read = req_empty_n. The pop latches base, num and rid, and clears counter i.
  - num>0 -> ISSUE. num==0 -> set err_zero, go directly to RESP with no reads.
- ISSUE:
  - One read per cycle: mem_rd_en=1, mem_rd_addr = base+i, with modulo 2^CHILD_IDX_W wrap and no carry out.
  - Each read pushes {valid, slot=i} into a MEM_LAT-deep shift register.
  - At i==num-1 -> DRAIN; otherwise i++.
- Return path, independent of state: when the shift register output is valid, sram_we=1, sram_waddr={slot, cid}, sram_wdata=mem_rd_data in that same cycle. No backpressure exists on memory or SRAM.
- DRAIN: when the shift register holds no valid entry (the last write occurs this cycle or earlier) -> RESP.
- RESP:
  - resp_write=1 and resp_din=rid held stable until resp_full_n=1.
  - On the accepted push -> IDLE.
  - resp_full_n low stalls indefinitely in RESP with no further pops.
- Latency, pop to response push with resp_full_n=1: num+MEM_LAT+1 cycles. Minimum request period is num+MEM_LAT+2 cycles. No request overlap.
- Slots 0..num-1 of the cid row are written in ascending order. Slots >= num are untouched.
- The request-stream read never fires outside IDLE. A request arriving during RESP waits.
- busy = (state!=IDLE) | any shift-register valid bit.

Optional Feature:
- IST_FETCH_TRACE_EN defined: on each pop, $display("IST %0d %0d", num_trigs, trig_idx). On each response push, $display("IST_DONE %0d", rid). A simulation assertion fires if num_trigs==0.
- IST_FETCH_TRACE_EN undefined: no display and no assertion. Functional behaviour is identical.

Decomposition:
- Shared package holds:
  - width defaults: RID/TID/CID/NUM_TRIGS/CHILD_IDX/TRIG
  - a packed request struct {trig_idx, num_trigs, rid} with its width constant
  - the FSM state enum
- One sub-module is natural: ist_lat_pipe, a parametrised valid+slot delay line of depth MEM_LAT, reusable for other fixed-latency memories.

Test Plan:
- Single request rid=0x2A5 (cid=0xA), num=3, trig_idx=100, MEM_LAT=2 -> reads at addr 100,101,102 on consecutive cycles; SRAM writes to {0,A},{1,A},{2,A} two cycles later with the matching data; resp_din=0x2A5 at pop+6 cycles.
- Wrap: trig_idx=0xFFFF, num=2 -> mem_rd_addr 0xFFFF then 0x0000; both written correctly.
- Zero count: num=0 -> no mem_rd_en and no sram_we; err_zero rises and stays 1; response for the rid is still pushed one cycle after the pop.
- Backpressure: resp_full_n=0 for 10 cycles during RESP -> resp_write/resp_din held constant, req_read=0 despite req_empty_n=1; push completes the cycle resp_full_n=1.
- Back-to-back: 20 random requests with num 1..7 and MEM_LAT in {1,4} -> SRAM contents match the reference model and responses arrive in request order.
- Reset mid-ISSUE: arst_n low with 2 reads in flight -> no subsequent sram_we or resp_write; after release the next request is processed normally.

Source files
------------

// File: rtl/ist_trig_fetch_pkg.sv
// ist_trig_fetch_pkg: shared widths, request bundle and FSM states
// for the IST triangle-fetch stage.
package ist_trig_fetch_pkg;

  localparam int DEF_RID_W       = 10;
  localparam int DEF_TID_W       = 6;
  localparam int DEF_CID_W       = 4;
  localparam int DEF_NUM_TRIGS_W = 3;
  localparam int DEF_CHILD_IDX_W = 16;
  localparam int DEF_TRIG_W      = 288;

  typedef struct packed {
    logic [DEF_CHILD_IDX_W-1:0] trig_idx;
    logic [DEF_NUM_TRIGS_W-1:0] num_trigs;
    logic [DEF_RID_W-1:0]       rid;
  } ist_req_t;

  localparam int REQ_W = $bits(ist_req_t);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    RESP
  } ist_state_e;

endpackage

// File: rtl/ist_trig_fetch_if.sv
// ist_trig_fetch_if: request pop / response push streams of the IST
// fetch stage. master = fetch stage, slave = the FIFOs around it.
interface ist_trig_fetch_if
  import ist_trig_fetch_pkg::*;
#(
  parameter int RID_W       = DEF_RID_W,
  parameter int NUM_TRIGS_W = DEF_NUM_TRIGS_W,
  parameter int CHILD_IDX_W = DEF_CHILD_IDX_W
) ();

  localparam int RQ_W = CHILD_IDX_W + NUM_TRIGS_W + RID_W;

  logic            req_empty_n;
  logic            req_read;
  logic [RQ_W-1:0] req_dout;
  logic            resp_full_n;
  logic            resp_write;
  logic [RID_W-1:0] resp_din;

  modport master (
    input  req_empty_n, req_dout, resp_full_n,
    output req_read, resp_write, resp_din
  );

  modport slave (
    output req_empty_n, req_dout, resp_full_n,
    input  req_read, resp_write, resp_din
  );

endinterface

// File: rtl/ist_lat_pipe.sv
// ist_lat_pipe: valid+slot delay line of DEPTH stages for a fixed-latency
// memory. Ports: in_valid/in_slot -> out_valid/out_slot; pending = any
// entry not yet at the output; any_valid = any entry at all.
module ist_lat_pipe #(
  parameter int DEPTH  = 2,
  parameter int SLOT_W = 3
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              in_valid,
  input  logic [SLOT_W-1:0] in_slot,
  output logic              out_valid,
  output logic [SLOT_W-1:0] out_slot,
  output logic              pending,
  output logic              any_valid
);

  logic [DEPTH-1:0]  vld;
  logic [SLOT_W-1:0] slot [DEPTH];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      vld <= '0;
      for (int k = 0; k < DEPTH; k++) slot[k] <= '0;
    end else begin
      vld[0]  <= in_valid;
      slot[0] <= in_slot;
      for (int k = 1; k < DEPTH; k++) begin
        vld[k]  <= vld[k-1];
        slot[k] <= slot[k-1];
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_slot  = slot[DEPTH-1];
  assign any_valid = |vld;
  // Entries behind the output stage still owe a write.
  assign pending   = |(vld & ~(DEPTH'(1) << (DEPTH-1)));

endmodule

// File: rtl/ist_trig_fetch.sv
// ist_trig_fetch: pops {trig_idx,num_trigs,rid}, reads num_trigs triangles
// from a MEM_LAT-cycle memory into SRAM row cid, then pushes rid.
// Ports: io (req/resp streams), mem_rd_*, sram_*, busy, err_zero.
// Optional: define IST_FETCH_TRACE_EN for pop/done trace and a zero-count
// assertion.
module ist_trig_fetch
  import ist_trig_fetch_pkg::*;
#(
  parameter int RID_W       = DEF_RID_W,
  parameter int TID_W       = DEF_TID_W,
  parameter int CID_W       = DEF_CID_W,
  parameter int NUM_TRIGS_W = DEF_NUM_TRIGS_W,
  parameter int CHILD_IDX_W = DEF_CHILD_IDX_W,
  parameter int TRIG_W      = DEF_TRIG_W,
  parameter int MEM_LAT     = 2
) (
  input  logic                         clk,
  input  logic                         arst_n,
  ist_trig_fetch_if.master             io,
  output logic                         mem_rd_en,
  output logic [CHILD_IDX_W-1:0]       mem_rd_addr,
  input  logic [TRIG_W-1:0]            mem_rd_data,
  output logic                         sram_we,
  output logic [NUM_TRIGS_W+CID_W-1:0] sram_waddr,
  output logic [TRIG_W-1:0]            sram_wdata,
  output logic                         busy,
  output logic                         err_zero
);

  ist_state_e state;

  logic [CHILD_IDX_W-1:0] addr_q;
  logic [NUM_TRIGS_W-1:0] num_q;
  logic [NUM_TRIGS_W-1:0] idx_q;
  logic [RID_W-1:0]       rid_q;
  logic                   rd_en_q;
  logic                   resp_wr_q;
  logic                   err_q;

  logic [CHILD_IDX_W-1:0] req_base;
  logic [NUM_TRIGS_W-1:0] req_num;
  logic [RID_W-1:0]       req_rid;

  logic                   out_vld;
  logic [NUM_TRIGS_W-1:0] out_slot;
  logic                   pending;
  logic                   any_vld;

  assign {req_base, req_num, req_rid} = io.req_dout;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      num_q     <= '0;
      idx_q     <= '0;
      rid_q     <= '0;
      rd_en_q   <= 1'b0;
      resp_wr_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (io.req_empty_n) begin
            addr_q <= req_base;
            num_q  <= req_num;
            rid_q  <= req_rid;
            idx_q  <= '0;
            if (req_num == '0) begin
              err_q     <= 1'b1;
              resp_wr_q <= 1'b1;
              state     <= RESP;
            end else begin
              rd_en_q <= 1'b1;
              state   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (idx_q == num_q - 1'b1) begin
            rd_en_q <= 1'b0;
            state   <= DRAIN;
          end else begin
            idx_q  <= idx_q + 1'b1;
            addr_q <= addr_q + 1'b1;
          end
        end
        DRAIN: begin
          if (!pending) begin
            resp_wr_q <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (io.resp_full_n) begin
            resp_wr_q <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  ist_lat_pipe #(
    .DEPTH  (MEM_LAT),
    .SLOT_W (NUM_TRIGS_W)
  ) u_pipe (
    .clk       (clk),
    .arst_n    (arst_n),
    .in_valid  (rd_en_q),
    .in_slot   (idx_q),
    .out_valid (out_vld),
    .out_slot  (out_slot),
    .pending   (pending),
    .any_valid (any_vld)
  );

  assign io.req_read   = (state == IDLE) & io.req_empty_n;
  assign io.resp_write = resp_wr_q;
  assign io.resp_din   = rid_q;

  assign mem_rd_en   = rd_en_q;
  assign mem_rd_addr = addr_q;

  assign sram_we    = out_vld;
  assign sram_waddr = out_vld ? {out_slot, rid_q[TID_W +: CID_W]} : '0;
  assign sram_wdata = out_vld ? mem_rd_data : '0;

  assign busy     = (state != IDLE) | any_vld;
  assign err_zero = err_q;

`ifdef IST_FETCH_TRACE_EN
  always_ff @(posedge clk) begin
    if (arst_n && io.req_read) begin
      $display("IST %0d %0d", req_num, req_base);
      assert (req_num != '0)
        else $error("ist_trig_fetch: zero-count request");
    end
    if (arst_n && io.resp_write && io.resp_full_n)
      $display("IST_DONE %0d", rid_q);
  end
`endif

endmodule

// File: tb/tb_ist_trig_fetch.sv
// tb_ist_trig_fetch: three instances (MEM_LAT 2,1,4) driven by queue-based
// FIFO/memory/SRAM models; scenario tasks check event logs.
module tb_ist_trig_fetch;
  import ist_trig_fetch_pkg::*;

  localparam int ND   = 3;
  localparam int SA_W = DEF_NUM_TRIGS_W + DEF_CID_W;
  localparam int NS   = 2 ** SA_W;

  typedef logic [DEF_CHILD_IDX_W-1:0] addr_t;
  typedef logic [DEF_TRIG_W-1:0]      trig_t;
  typedef logic [DEF_RID_W-1:0]       rid_t;
  typedef logic [SA_W-1:0]            sa_t;

  typedef struct { int cyc; addr_t addr; } rd_ev_t;
  typedef struct { int cyc; sa_t waddr; trig_t data; } wr_ev_t;
  typedef struct { int cyc; rid_t rid; } rs_ev_t;
  typedef struct { int cyc; ist_req_t req; } pop_ev_t;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;

  logic     req_empty_n [ND];
  logic     req_read    [ND];
  ist_req_t req_dout    [ND];
  logic     resp_full_n [ND];
  logic     resp_write  [ND];
  rid_t     resp_din    [ND];
  logic     mem_rd_en   [ND];
  addr_t    mem_rd_addr [ND];
  trig_t    mem_rd_data [ND];
  logic     sram_we     [ND];
  sa_t      sram_waddr  [ND];
  trig_t    sram_wdata  [ND];
  logic     busy        [ND];
  logic     err_zero    [ND];

  bit       hold [ND];
  ist_req_t req_q [ND][$];
  rd_ev_t   mq [ND][$];
  rd_ev_t   rd_log [ND][$];
  wr_ev_t   wr_log [ND][$];
  rs_ev_t   rs_log [ND][$];
  pop_ev_t  pop_log [ND][$];
  trig_t    sram_m [ND][NS];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int L = (g == 1) ? 1 : ((g == 2) ? 4 : 2);
    ist_trig_fetch_if #(
      .RID_W       (DEF_RID_W),
      .NUM_TRIGS_W (DEF_NUM_TRIGS_W),
      .CHILD_IDX_W (DEF_CHILD_IDX_W)
    ) bus ();
    assign bus.req_empty_n = req_empty_n[g];
    assign bus.req_dout    = req_dout[g];
    assign bus.resp_full_n = resp_full_n[g];
    assign req_read[g]     = bus.req_read;
    assign resp_write[g]   = bus.resp_write;
    assign resp_din[g]     = bus.resp_din;
    ist_trig_fetch #(
      .RID_W       (DEF_RID_W),
      .TID_W       (DEF_TID_W),
      .CID_W       (DEF_CID_W),
      .NUM_TRIGS_W (DEF_NUM_TRIGS_W),
      .CHILD_IDX_W (DEF_CHILD_IDX_W),
      .TRIG_W      (DEF_TRIG_W),
      .MEM_LAT     (L)
    ) dut (
      .clk         (clk),
      .arst_n      (arst_n),
      .io          (bus),
      .mem_rd_en   (mem_rd_en[g]),
      .mem_rd_addr (mem_rd_addr[g]),
      .mem_rd_data (mem_rd_data[g]),
      .sram_we     (sram_we[g]),
      .sram_waddr  (sram_waddr[g]),
      .sram_wdata  (sram_wdata[g]),
      .busy        (busy[g]),
      .err_zero    (err_zero[g])
    );
  end

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(int g);
    return (g == 1) ? 1 : ((g == 2) ? 4 : 2);
  endfunction

  function automatic trig_t trig_of(addr_t a);
    trig_t r;
    for (int j = 0; j < 9; j++)
      r[j*32 +: 32] = ({16'h0, a} * 32'h9E3779B1) ^ (32'(j) * 32'h01010101)
                      ^ 32'h5A5A0000;
    return r;
  endfunction

  // Environment: request FIFOs, backing memory, SRAM and event monitors.
  initial begin
    for (int g = 0; g < ND; g++) begin
      req_empty_n[g] = 1'b0;
      req_dout[g]    = '0;
      resp_full_n[g] = 1'b1;
      mem_rd_data[g] = '0;
      hold[g]        = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int g = 0; g < ND; g++) begin
        req_empty_n[g] = (req_q[g].size() != 0);
        req_dout[g]    = req_empty_n[g] ? req_q[g][0] : '0;
        resp_full_n[g] = !hold[g];
        while (mq[g].size() != 0 && mq[g][0].cyc < cyc - lat_of(g))
          void'(mq[g].pop_front());
        if (mq[g].size() != 0 && mq[g][0].cyc == cyc - lat_of(g))
          mem_rd_data[g] = trig_of(mq[g][0].addr);
        else
          mem_rd_data[g] = {9{$urandom()}};
      end
      #3;
      for (int g = 0; g < ND; g++) begin
        if (mem_rd_en[g]) begin
          rd_log[g].push_back('{cyc, mem_rd_addr[g]});
          mq[g].push_back('{cyc, mem_rd_addr[g]});
        end
        if (sram_we[g]) begin
          sram_m[g][sram_waddr[g]] = sram_wdata[g];
          wr_log[g].push_back('{cyc, sram_waddr[g], sram_wdata[g]});
        end
        if (resp_write[g] && resp_full_n[g])
          rs_log[g].push_back('{cyc, resp_din[g]});
        if (req_read[g] && req_empty_n[g])
          pop_log[g].push_back('{cyc, req_q[g].pop_front()});
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #4;
  endtask

  task automatic clear_logs(int g);
    rd_log[g].delete();
    wr_log[g].delete();
    rs_log[g].delete();
    pop_log[g].delete();
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    repeat (3) tick();
    for (int g = 0; g < ND; g++) begin
      checks++;
      if ({req_read[g], resp_write[g], mem_rd_en[g], sram_we[g],
           busy[g], err_zero[g]} !== 6'b0) begin
        fails++;
        $display("FAIL reset_ctl[%0d]: got %b%b%b%b%b%b expected 000000", g,
                 req_read[g], resp_write[g], mem_rd_en[g], sram_we[g],
                 busy[g], err_zero[g]);
      end
      checks++;
      if ({resp_din[g], mem_rd_addr[g], sram_waddr[g], sram_wdata[g]} !== '0) begin
        fails++;
        $display("FAIL reset_bus[%0d]: got %h %h %h expected 0", g,
                 resp_din[g], mem_rd_addr[g], sram_waddr[g]);
      end
    end
    arst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_single();
    int to, p;
    clear_logs(0);
    req_q[0].push_back('{16'd100, 3'd3, 10'h2A5});
    to = 0;
    while (rs_log[0].size() == 0 && to < 60) begin tick(); to++; end
    repeat (4) tick();
    checks++;
    if (rs_log[0].size() != 1 || pop_log[0].size() != 1) begin
      fails++;
      $display("FAIL single_done: got %0d resp %0d pops expected 1 1",
               rs_log[0].size(), pop_log[0].size());
      return;
    end
    p = pop_log[0][0].cyc;
    checks++;
    if (rd_log[0].size() != 3 || wr_log[0].size() != 3) begin
      fails++;
      $display("FAIL single_cnt: got %0d rd %0d wr expected 3 3",
               rd_log[0].size(), wr_log[0].size());
    end
    for (int k = 0; k < 3 && k < rd_log[0].size(); k++) begin
      checks++;
      if (rd_log[0][k].cyc !== p + 1 + k || rd_log[0][k].addr !== 16'(100 + k)) begin
        fails++;
        $display("FAIL single_rd%0d: got cyc %0d addr %0d expected %0d %0d", k,
                 rd_log[0][k].cyc, rd_log[0][k].addr, p + 1 + k, 100 + k);
      end
    end
    for (int k = 0; k < 3 && k < wr_log[0].size(); k++) begin
      checks++;
      if (wr_log[0][k].cyc !== p + 3 + k || wr_log[0][k].waddr !== sa_t'(k * 16 + 'hA)
          || wr_log[0][k].data !== trig_of(16'(100 + k))) begin
        fails++;
        $display("FAIL single_wr%0d: got cyc %0d addr %h expected %0d %h", k,
                 wr_log[0][k].cyc, wr_log[0][k].waddr, p + 3 + k, k * 16 + 'hA);
      end
    end
    checks++;
    if (rs_log[0][0].cyc !== p + 6 || rs_log[0][0].rid !== 10'h2A5) begin
      fails++;
      $display("FAIL single_resp: got cyc %0d rid %h expected %0d 2a5",
               rs_log[0][0].cyc - p, rs_log[0][0].rid, 6);
    end
    checks++;
    if (busy[0] !== 1'b0 || err_zero[0] !== 1'b0) begin
      fails++;
      $display("FAIL single_idle: got busy %b err %b expected 0 0",
               busy[0], err_zero[0]);
    end
  endtask

  task automatic test_wrap();
    int to, p;
    clear_logs(0);
    req_q[0].push_back('{16'hFFFF, 3'd2, 10'h155});
    to = 0;
    while (rs_log[0].size() == 0 && to < 60) begin tick(); to++; end
    checks++;
    if (rs_log[0].size() != 1 || rd_log[0].size() != 2 || wr_log[0].size() != 2) begin
      fails++;
      $display("FAIL wrap_cnt: got %0d resp %0d rd %0d wr expected 1 2 2",
               rs_log[0].size(), rd_log[0].size(), wr_log[0].size());
      return;
    end
    p = pop_log[0][0].cyc;
    checks++;
    if (rd_log[0][0].addr !== 16'hFFFF || rd_log[0][1].addr !== 16'h0000) begin
      fails++;
      $display("FAIL wrap_addr: got %h %h expected ffff 0000",
               rd_log[0][0].addr, rd_log[0][1].addr);
    end
    checks++;
    if (wr_log[0][0].waddr !== 7'h05 || wr_log[0][1].waddr !== 7'h15
        || wr_log[0][0].data !== trig_of(16'hFFFF)
        || wr_log[0][1].data !== trig_of(16'h0000)) begin
      fails++;
      $display("FAIL wrap_wr: got %h %h expected 05 15",
               wr_log[0][0].waddr, wr_log[0][1].waddr);
    end
    checks++;
    if (rs_log[0][0].cyc !== p + 5 || rs_log[0][0].rid !== 10'h155) begin
      fails++;
      $display("FAIL wrap_resp: got lat %0d rid %h expected 5 155",
               rs_log[0][0].cyc - p, rs_log[0][0].rid);
    end
  endtask

  task automatic test_zero();
    int to, p;
    repeat (2) tick();
    clear_logs(0);
    req_q[0].push_back('{16'd7, 3'd0, 10'h0C3});
    to = 0;
    while (rs_log[0].size() == 0 && to < 30) begin tick(); to++; end
    checks++;
    if (rs_log[0].size() != 1 || pop_log[0].size() != 1) begin
      fails++;
      $display("FAIL zero_done: got %0d resp expected 1", rs_log[0].size());
      return;
    end
    p = pop_log[0][0].cyc;
    checks++;
    if (rs_log[0][0].cyc !== p + 1 || rs_log[0][0].rid !== 10'h0C3) begin
      fails++;
      $display("FAIL zero_resp: got lat %0d rid %h expected 1 0c3",
               rs_log[0][0].cyc - p, rs_log[0][0].rid);
    end
    repeat (5) tick();
    checks++;
    if (rd_log[0].size() != 0 || wr_log[0].size() != 0) begin
      fails++;
      $display("FAIL zero_noacc: got %0d rd %0d wr expected 0 0",
               rd_log[0].size(), wr_log[0].size());
    end
    checks++;
    if (err_zero[0] !== 1'b1) begin
      fails++;
      $display("FAIL zero_err: got %b expected 1", err_zero[0]);
    end
  endtask

  task automatic test_backpressure();
    int to, rel;
    clear_logs(0);
    hold[0] = 1'b1;
    req_q[0].push_back('{16'd200, 3'd2, 10'h3FF});
    req_q[0].push_back('{16'd300, 3'd1, 10'h001});
    to = 0;
    while (resp_write[0] !== 1'b1 && to < 40) begin tick(); to++; end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (resp_write[0] !== 1'b1 || resp_din[0] !== 10'h3FF
          || req_read[0] !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold%0d: got wr %b din %h rd %b expected 1 3ff 0",
                 k, resp_write[0], resp_din[0], req_read[0]);
      end
      tick();
    end
    hold[0] = 1'b0;
    tick();
    rel = cyc;
    to = 0;
    while (rs_log[0].size() < 2 && to < 40) begin tick(); to++; end
    checks++;
    if (rs_log[0].size() != 2 || pop_log[0].size() != 2) begin
      fails++;
      $display("FAIL bp_done: got %0d resp expected 2", rs_log[0].size());
      return;
    end
    checks++;
    if (rs_log[0][0].cyc !== rel || rs_log[0][0].rid !== 10'h3FF) begin
      fails++;
      $display("FAIL bp_push: got cyc %0d rid %h expected %0d 3ff",
               rs_log[0][0].cyc, rs_log[0][0].rid, rel);
    end
    checks++;
    if (pop_log[0][1].cyc !== rel + 1 || rs_log[0][1].rid !== 10'h001) begin
      fails++;
      $display("FAIL bp_next: got cyc %0d rid %h expected %0d 001",
               pop_log[0][1].cyc, rs_log[0][1].rid, rel + 1);
    end
  endtask

  task automatic test_back_to_back(int g);
    int to, nw, l;
    ist_req_t reqs[20];
    trig_t exp_m [NS];
    l = lat_of(g);
    clear_logs(g);
    for (int s = 0; s < NS; s++) begin sram_m[g][s] = '0; exp_m[s] = '0; end
    nw = 0;
    for (int k = 0; k < 20; k++) begin
      reqs[k].trig_idx  = 16'($urandom());
      reqs[k].num_trigs = 3'($urandom_range(1, 7));
      reqs[k].rid       = 10'($urandom());
      nw += int'(reqs[k].num_trigs);
      for (int s = 0; s < int'(reqs[k].num_trigs); s++)
        exp_m[s * 16 + int'(reqs[k].rid[9:6])] = trig_of(16'(reqs[k].trig_idx + s));
      req_q[g].push_back(reqs[k]);
    end
    to = 0;
    while (rs_log[g].size() < 20 && to < 400) begin tick(); to++; end
    checks++;
    if (rs_log[g].size() != 20 || pop_log[g].size() != 20) begin
      fails++;
      $display("FAIL b2b_done[L%0d]: got %0d resp expected 20", l, rs_log[g].size());
      return;
    end
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (rs_log[g][k].rid !== reqs[k].rid
          || rs_log[g][k].cyc - pop_log[g][k].cyc !== int'(reqs[k].num_trigs) + l + 1) begin
        fails++;
        $display("FAIL b2b_resp[L%0d.%0d]: got rid %h lat %0d expected %h %0d", l, k,
                 rs_log[g][k].rid, rs_log[g][k].cyc - pop_log[g][k].cyc,
                 reqs[k].rid, int'(reqs[k].num_trigs) + l + 1);
      end
      if (k > 0) begin
        checks++;
        if (pop_log[g][k].cyc - pop_log[g][k-1].cyc
            !== int'(reqs[k-1].num_trigs) + l + 2) begin
          fails++;
          $display("FAIL b2b_period[L%0d.%0d]: got %0d expected %0d", l, k,
                   pop_log[g][k].cyc - pop_log[g][k-1].cyc,
                   int'(reqs[k-1].num_trigs) + l + 2);
        end
      end
    end
    checks++;
    if (wr_log[g].size() != nw) begin
      fails++;
      $display("FAIL b2b_nwr[L%0d]: got %0d expected %0d", l, wr_log[g].size(), nw);
    end
    for (int s = 0; s < NS; s++) begin
      checks++;
      if (sram_m[g][s] !== exp_m[s]) begin
        fails++;
        $display("FAIL b2b_sram[L%0d.%0h]: got %h expected %h", l, s,
                 sram_m[g][s][31:0], exp_m[s][31:0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int to, p;
    clear_logs(0);
    req_q[0].push_back('{16'd300, 3'd5, 10'h111});
    to = 0;
    while (rd_log[0].size() < 2 && to < 30) begin tick(); to++; end
    arst_n = 1'b0;
    clear_logs(0);
    repeat (2) tick();
    arst_n = 1'b1;
    repeat (10) tick();
    checks++;
    if (wr_log[0].size() != 0 || rs_log[0].size() != 0) begin
      fails++;
      $display("FAIL rst_mid_quiet: got %0d wr %0d resp expected 0 0",
               wr_log[0].size(), rs_log[0].size());
    end
    checks++;
    if (busy[0] !== 1'b0 || err_zero[0] !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_state: got busy %b err %b expected 0 0",
               busy[0], err_zero[0]);
    end
    clear_logs(0);
    req_q[0].push_back('{16'd500, 3'd4, 10'h2C0});
    to = 0;
    while (rs_log[0].size() == 0 && to < 40) begin tick(); to++; end
    checks++;
    if (rs_log[0].size() != 1 || wr_log[0].size() != 4) begin
      fails++;
      $display("FAIL rst_mid_next: got %0d resp %0d wr expected 1 4",
               rs_log[0].size(), wr_log[0].size());
      return;
    end
    p = pop_log[0][0].cyc;
    checks++;
    if (rs_log[0][0].cyc !== p + 7 || rs_log[0][0].rid !== 10'h2C0) begin
      fails++;
      $display("FAIL rst_mid_resp: got lat %0d rid %h expected 7 2c0",
               rs_log[0][0].cyc - p, rs_log[0][0].rid);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (wr_log[0][k].waddr !== sa_t'(k * 16 + 'hB)
          || wr_log[0][k].data !== trig_of(16'(500 + k))) begin
        fails++;
        $display("FAIL rst_mid_wr%0d: got %h expected %h", k,
                 wr_log[0][k].waddr, k * 16 + 'hB);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_zero();
    test_backpressure();
    test_back_to_back(1);
    test_back_to_back(2);
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
